// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / fetch sequencer:
// FSM state encoding, PC step and jump-field width, plus small
// address helpers used by the next-PC selection.
package pc_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        RESOLVE = 2'd2,
        ERRO    = 2'd3
    } estado_t;

    localparam logic [31:0] INCREMENTO_PC = 32'd4;
    localparam int          LARGURA_SALTO = 26;

    // Jump target: keep the region bits of PC+4, drop in the word index.
    function automatic logic [31:0] alvo_salto(
        input logic [31:0]              pc_seq,
        input logic [LARGURA_SALTO-1:0] indice
    );
        return {pc_seq[31:28], indice, 2'b00};
    endfunction

    // A fetch address must be word aligned.
    function automatic logic desalinhado(input logic [31:0] endereco);
        return (endereco[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/extensor_sinal_shift.sv
// Sign-extends the instruction immediate and scales it to a byte
// offset (shift left by 2). Purely combinational; the caller registers it.
module extensor_sinal_shift
    import pc_pkg::*;
#(
    parameter int LARGURA_IMEDIATO = 16
) (
    input  logic [LARGURA_IMEDIATO-1:0] imediato,
    output logic [31:0]                 sinal_shift
);

    assign sinal_shift = {{(30-LARGURA_IMEDIATO){imediato[LARGURA_IMEDIATO-1]}},
                          imediato, 2'b00};

endmodule

// File: rtl/gerador_pc.sv
// Program counter and fetch sequencer. Issues a valid/ready fetch for
// pc_atual, captures the scaled immediate for the external branch adder,
// resolves jump/branch/sequential next PC and counts retired instructions.
// All outputs come straight from registers.
module gerador_pc
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          LARGURA_IMEDIATO = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LARGURA_IMEDIATO-1:0] imediato,
    input  logic                        busca_pronta,
    output logic                        busca_valida,
    output logic [31:0]                 pc_atual,
    output logic [31:0]                 pc,
    output logic [31:0]                 sinal_shift,
    input  logic [31:0]                 saida_mux,
    input  logic                        desvio,
    input  logic                        salto,
    input  logic [LARGURA_SALTO-1:0]    endereco_salto,
    input  logic                        parada,
    output logic                        erro_alinhamento,
    output logic [31:0]                 contador_instrucoes
);

    estado_t     estado_r;
    estado_t     estado_prox_s;

    logic [31:0] pc_atual_r;
    logic [31:0] pc_r;
    logic [31:0] sinal_shift_r;
    logic        busca_valida_r;
    logic        erro_r;
    logic [31:0] contador_r;

    logic [31:0] pc_atual_prox_s;
    logic [31:0] pc_prox_s;
    logic [31:0] sinal_shift_prox_s;
    logic        busca_valida_prox_s;
    logic        erro_prox_s;
    logic [31:0] contador_prox_s;

    logic [31:0] sinal_shift_ext_s;
    logic [31:0] pc_destino_s;
    logic        aceita_s;
    logic        desvio_ruim_s;

    extensor_sinal_shift #(
        .LARGURA_IMEDIATO(LARGURA_IMEDIATO)
    ) u_extensor (
        .imediato    (imediato),
        .sinal_shift (sinal_shift_ext_s)
    );

    // Fetch accept, next-PC selection (jump > branch > sequential) and misaligned-branch detection.
    always_comb begin
        aceita_s      = (estado_r == BUSCA) && busca_pronta && !parada;
        desvio_ruim_s = desvio && !salto && desalinhado(saida_mux);
        if (salto) begin
            pc_destino_s = alvo_salto(pc_r, endereco_salto);
        end else if (desvio) begin
            pc_destino_s = saida_mux;
        end else begin
            pc_destino_s = pc_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        estado_prox_s = estado_r;
        case (estado_r)
            OCIOSO: begin
                estado_prox_s = BUSCA;
            end
            BUSCA: begin
                if (aceita_s) begin
                    estado_prox_s = RESOLVE;
                end else begin
                    estado_prox_s = BUSCA;
                end
            end
            RESOLVE: begin
                if (parada) begin
                    estado_prox_s = RESOLVE;
                end else if (desvio_ruim_s) begin
                    estado_prox_s = ERRO;
                end else begin
                    estado_prox_s = BUSCA;
                end
            end
            ERRO: begin
                estado_prox_s = ERRO;
            end
            default: begin
                estado_prox_s = OCIOSO;
            end
        endcase
    end

    // FSM output logic: next values for every registered output.
    always_comb begin
        pc_atual_prox_s     = pc_atual_r;
        pc_prox_s           = pc_r;
        sinal_shift_prox_s  = sinal_shift_r;
        erro_prox_s         = erro_r;
        contador_prox_s     = contador_r;
        busca_valida_prox_s = (estado_prox_s == BUSCA);
        case (estado_r)
            BUSCA: begin
                if (aceita_s) begin
                    sinal_shift_prox_s = sinal_shift_ext_s;
                end else begin
                    sinal_shift_prox_s = sinal_shift_r;
                end
            end
            RESOLVE: begin
                if (parada) begin
                    pc_atual_prox_s = pc_atual_r;
                end else if (desvio_ruim_s) begin
                    erro_prox_s = 1'b1;
                end else begin
                    pc_atual_prox_s = pc_destino_s;
                    pc_prox_s       = pc_destino_s + INCREMENTO_PC;
                    contador_prox_s = contador_r + 32'd1;
                end
            end
            OCIOSO: begin
                pc_atual_prox_s = pc_atual_r;
            end
            ERRO: begin
                pc_atual_prox_s = pc_atual_r;
            end
            default: begin
                pc_atual_prox_s = pc_atual_r;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_atual_r     <= RESET_PC;
            pc_r           <= RESET_PC + INCREMENTO_PC;
            sinal_shift_r  <= 32'd0;
            busca_valida_r <= 1'b0;
            erro_r         <= 1'b0;
            contador_r     <= 32'd0;
        end else begin
            pc_atual_r     <= pc_atual_prox_s;
            pc_r           <= pc_prox_s;
            sinal_shift_r  <= sinal_shift_prox_s;
            busca_valida_r <= busca_valida_prox_s;
            erro_r         <= erro_prox_s;
            contador_r     <= contador_prox_s;
        end
    end

    assign busca_valida        = busca_valida_r;
    assign pc_atual            = pc_atual_r;
    assign pc                  = pc_r;
    assign sinal_shift         = sinal_shift_r;
    assign erro_alinhamento    = erro_r;
    assign contador_instrucoes = contador_r;

endmodule

// File: tb/tb_gerador_pc.sv
// Bench for gerador_pc: table of per-cycle stimulus/expectations fed
// through a scoreboard queue, plus a hand-written wrap-around sequence
// on a second instance reset to 32'hFFFF_FFFC.
module tb_gerador_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imediato;
    logic        busca_pronta;
    logic        desvio;
    logic        salto;
    logic [25:0] endereco_salto;
    logic        parada;
    logic        usa_modelo;
    logic [31:0] saida_forcada;

    logic        busca_valida, erro_alinhamento;
    logic [31:0] pc_atual, pc, sinal_shift, saida_mux, contador_instrucoes;

    logic        busca_valida2, erro_alinhamento2;
    logic [31:0] pc_atual2, pc2, sinal_shift2, saida_mux2, contador_instrucoes2;

    int erros  = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        pronta;
        logic        para;
        logic        dv;
        logic        sl;
        logic [15:0] imm;
        logic [25:0] ender;
        logic        modelo;
        logic [31:0] forcada;
        logic        e_valida;
        logic [31:0] e_pc_atual;
        logic [31:0] e_pc;
        logic [31:0] e_ss;
        logic        e_erro;
        logic [31:0] e_cnt;
    } vetor_t;

    vetor_t tabela[$];
    vetor_t esperado[$];

    // Branch-target adder model
    assign saida_mux  = usa_modelo ? (pc + sinal_shift) : saida_forcada;
    assign saida_mux2 = pc2 + sinal_shift2;

    always #5 clk = ~clk;

    gerador_pc #(.RESET_PC(32'h0000_0000), .LARGURA_IMEDIATO(16)) dut (
        .clk(clk), .reset(reset), .imediato(imediato), .busca_pronta(busca_pronta),
        .busca_valida(busca_valida), .pc_atual(pc_atual), .pc(pc), .sinal_shift(sinal_shift),
        .saida_mux(saida_mux), .desvio(desvio), .salto(salto), .endereco_salto(endereco_salto),
        .parada(parada), .erro_alinhamento(erro_alinhamento),
        .contador_instrucoes(contador_instrucoes)
    );

    gerador_pc #(.RESET_PC(32'hFFFF_FFFC), .LARGURA_IMEDIATO(16)) dut_wrap (
        .clk(clk), .reset(reset), .imediato(imediato), .busca_pronta(busca_pronta),
        .busca_valida(busca_valida2), .pc_atual(pc_atual2), .pc(pc2), .sinal_shift(sinal_shift2),
        .saida_mux(saida_mux2), .desvio(desvio), .salto(salto), .endereco_salto(endereco_salto),
        .parada(parada), .erro_alinhamento(erro_alinhamento2),
        .contador_instrucoes(contador_instrucoes2)
    );

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] req);
        checks++;
        if (atual !== req) begin
            erros++;
            $display("FAIL %s: got %h expected %h", nome, atual, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic pr, input logic pa, input logic dv,
                       input logic sl, input logic [15:0] imm, input logic [25:0] en,
                       input logic md, input logic [31:0] fo, input logic ev,
                       input logic [31:0] epa, input logic [31:0] epc, input logic [31:0] ess,
                       input logic eer, input logic [31:0] ecnt);
        vetor_t v;
        v.rst = rst; v.pronta = pr; v.para = pa; v.dv = dv; v.sl = sl;
        v.imm = imm; v.ender = en; v.modelo = md; v.forcada = fo;
        v.e_valida = ev; v.e_pc_atual = epa; v.e_pc = epc; v.e_ss = ess;
        v.e_erro = eer; v.e_cnt = ecnt;
        tabela.push_back(v);
    endtask

    initial begin
        vetor_t v, e;

        // rst pr pa dv sl imm       ender   md forcada        | v  pc_atual       pc               sinal_shift      er cnt
        add(1, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 0 reset
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 1 first fetch
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 2 resolve
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_0004, 32'h0000_0008, 32'h0000_0000, 0, 32'd1); // 3
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_0004, 32'h0000_0008, 32'h0000_0000, 0, 32'd1); // 4
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 0, 32'd2); // 5
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_0008, 32'h0000_000C, 32'h0000_0000, 0, 32'd2); // 6
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_000C, 32'h0000_0010, 32'h0000_0000, 0, 32'd3); // 7
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_000C, 32'h0000_0010, 32'h0000_0000, 0, 32'd3); // 8
        add(0, 1, 0, 0, 1, 16'h0000, 26'h40, 1, 32'h0,          1, 32'h0000_0100, 32'h0000_0104, 32'h0000_0000, 0, 32'd4); // 9 jump to 0x100
        add(0, 1, 0, 0, 0, 16'hFFFE, 26'h0,  1, 32'h0,          0, 32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFF8, 0, 32'd4); // 10 negative imm
        add(0, 1, 0, 1, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_00FC, 32'h0000_0100, 32'hFFFF_FFF8, 0, 32'd5); // 11 branch taken
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_00FC, 32'h0000_0100, 32'h0000_0000, 0, 32'd5); // 12
        add(0, 1, 0, 1, 0, 16'h0000, 26'h0,  0, 32'h1000_0000,  1, 32'h1000_0000, 32'h1000_0004, 32'h0000_0000, 0, 32'd6); // 13 far branch
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h1000_0000, 32'h1000_0004, 32'h0000_0000, 0, 32'd6); // 14
        add(0, 1, 0, 1, 1, 16'h0000, 26'h40, 0, 32'h2000_0000,  1, 32'h1000_0100, 32'h1000_0104, 32'h0000_0000, 0, 32'd7); // 15 jump beats branch
        add(0, 0, 0, 0, 0, 16'h0003, 26'h0,  1, 32'h0,          1, 32'h1000_0100, 32'h1000_0104, 32'h0000_0000, 0, 32'd7); // 16 not ready
        add(0, 0, 0, 0, 0, 16'h0003, 26'h0,  1, 32'h0,          1, 32'h1000_0100, 32'h1000_0104, 32'h0000_0000, 0, 32'd7); // 17
        add(0, 0, 0, 0, 0, 16'h0003, 26'h0,  1, 32'h0,          1, 32'h1000_0100, 32'h1000_0104, 32'h0000_0000, 0, 32'd7); // 18
        add(0, 1, 1, 0, 0, 16'h0003, 26'h0,  1, 32'h0,          1, 32'h1000_0100, 32'h1000_0104, 32'h0000_0000, 0, 32'd7); // 19 ready+stall
        add(0, 1, 1, 0, 0, 16'h0003, 26'h0,  1, 32'h0,          1, 32'h1000_0100, 32'h1000_0104, 32'h0000_0000, 0, 32'd7); // 20
        add(0, 1, 0, 0, 0, 16'h0003, 26'h0,  1, 32'h0,          0, 32'h1000_0100, 32'h1000_0104, 32'h0000_000C, 0, 32'd7); // 21 accept
        add(0, 1, 1, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h1000_0100, 32'h1000_0104, 32'h0000_000C, 0, 32'd7); // 22 stall in resolve
        add(0, 1, 0, 1, 0, 16'h0000, 26'h0,  0, 32'h0000_0102,  0, 32'h1000_0100, 32'h1000_0104, 32'h0000_000C, 1, 32'd7); // 23 misaligned
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h1000_0100, 32'h1000_0104, 32'h0000_000C, 1, 32'd7); // 24 error held
        add(1, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 25 reset clears
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 26
        add(0, 1, 0, 0, 0, 16'h0010, 26'h0,  1, 32'h0,          0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0040, 0, 32'd0); // 27 accept
        add(1, 1, 0, 1, 0, 16'h0000, 26'h0,  1, 32'h0,          0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 28 reset in resolve
        add(0, 1, 0, 0, 0, 16'h0000, 26'h0,  1, 32'h0,          1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 0, 32'd0); // 29

        for (int i = 0; i < tabela.size(); i++) begin
            v = tabela[i];
            reset          = v.rst;
            busca_pronta   = v.pronta;
            parada         = v.para;
            desvio         = v.dv;
            salto          = v.sl;
            imediato       = v.imm;
            endereco_salto = v.ender;
            usa_modelo     = v.modelo;
            saida_forcada  = v.forcada;
            esperado.push_back(v);
            step();
            e = esperado.pop_front();
            chk($sformatf("v%0d busca_valida", i), {31'd0, busca_valida}, {31'd0, e.e_valida});
            chk($sformatf("v%0d pc_atual", i), pc_atual, e.e_pc_atual);
            chk($sformatf("v%0d pc", i), pc, e.e_pc);
            chk($sformatf("v%0d sinal_shift", i), sinal_shift, e.e_ss);
            chk($sformatf("v%0d erro", i), {31'd0, erro_alinhamento}, {31'd0, e.e_erro});
            chk($sformatf("v%0d contador", i), contador_instrucoes, e.e_cnt);
        end

        // PC wrap-around on the instance reset to the top of the address space
        reset = 1'b1; busca_pronta = 1'b1; parada = 1'b0; desvio = 1'b0; salto = 1'b0;
        imediato = 16'h0000; endereco_salto = 26'h0;
        step();
        chk("wrap reset pc_atual", pc_atual2, 32'hFFFF_FFFC);
        chk("wrap reset pc", pc2, 32'h0000_0000);
        reset = 1'b0;
        step();
        chk("wrap fetch valida", {31'd0, busca_valida2}, 32'd1);
        step();
        chk("wrap resolve valida", {31'd0, busca_valida2}, 32'd0);
        step();
        chk("wrap next pc_atual", pc_atual2, 32'h0000_0000);
        chk("wrap next pc", pc2, 32'h0000_0004);
        chk("wrap contador", contador_instrucoes2, 32'd1);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
